// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage LEGv8 pipeline: load-use stalls,
// taken-branch flushes, memory-busy freezes, saturating event counters and a sticky error flag.
module hazard_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [4:0]       ifid_rn,
    input  logic [4:0]       ifid_rm,
    input  logic             ifid_uses_rm,
    input  logic             idex_memread,
    input  logic [4:0]       idex_write_reg,
    input  logic             branch_taken,
    input  logic             dmem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             pipe_freeze,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt,
    output logic             err
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_STALL  = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;
    localparam logic [1:0] ST_FREEZE = 2'd3;

    localparam int RUN_W = $clog2(TIMEOUT + 1);

    logic             lu;
    logic [1:0]       act;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;
    logic [RUN_W-1:0] frz_run_q, frz_run_d;
    logic             err_q, err_d;

    // X31 is XZR: a load targeting it never produces a value to wait for.
    assign lu = idex_memread && (idex_write_reg != 5'd31) &&
                ((idex_write_reg == ifid_rn) ||
                 (ifid_uses_rm && (idex_write_reg == ifid_rm)));

    always_comb begin
        act = ST_RUN;
        if (dmem_busy)         act = ST_FREEZE;
        else if (branch_taken) act = ST_FLUSH;
        else if (lu)           act = ST_STALL;
    end

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        pipe_freeze = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end else begin
            case (act)
                ST_FREEZE: begin
                    pipe_freeze = 1'b1;
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                end
                ST_FLUSH: begin
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                end
                ST_STALL: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d      = act;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        freeze_cnt_d = freeze_cnt_q;
        frz_run_d    = '0;
        err_d        = err_q;
        if ((act == ST_STALL) && (stall_cnt_q != '1))   stall_cnt_d  = stall_cnt_q + 1'b1;
        if ((act == ST_FLUSH) && (flush_cnt_q != '1))   flush_cnt_d  = flush_cnt_q + 1'b1;
        if ((act == ST_FREEZE) && (freeze_cnt_q != '1)) freeze_cnt_d = freeze_cnt_q + 1'b1;
        if (act == ST_FREEZE) begin
            // The run count holds at TIMEOUT so a very long freeze cannot wrap it.
            frz_run_d = frz_run_q;
            if (frz_run_q != RUN_W'(TIMEOUT)) frz_run_d = frz_run_q + 1'b1;
            if (frz_run_d == RUN_W'(TIMEOUT)) err_d = 1'b1;
        end
        // A bubble leaves no load in ID/EX, so a second consecutive stall is a protocol error.
        if ((act == ST_STALL) && (state_q == ST_STALL)) err_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_RUN;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            freeze_cnt_q <= '0;
            frz_run_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
            frz_run_q    <= frz_run_d;
            err_q        <= err_d;
        end
    end

    assign state      = state_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign freeze_cnt = freeze_cnt_q;
    assign err        = err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: hand-computed control outputs, state codes, counters and error flag.
module tb_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  ifid_rn, ifid_rm, idex_write_reg;
    logic        ifid_uses_rm, idex_memread, branch_taken, dmem_busy;
    logic        pc_write, ifid_write, idex_bubble;
    logic        ifid_flush, idex_flush, exmem_flush, pipe_freeze;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt, freeze_cnt;
    logic        err;

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(.TIMEOUT(64), .CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .ifid_rn(ifid_rn), .ifid_rm(ifid_rm), .ifid_uses_rm(ifid_uses_rm),
        .idex_memread(idex_memread), .idex_write_reg(idex_write_reg),
        .branch_taken(branch_taken), .dmem_busy(dmem_busy),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .pipe_freeze(pipe_freeze), .state(state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt),
        .err(err)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Packs {pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, exmem_flush, pipe_freeze}.
    function automatic logic [31:0] ctl();
        return {25'd0, pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush,
                exmem_flush, pipe_freeze};
    endfunction

    localparam logic [31:0] CTL_RESET  = 32'b0011110;
    localparam logic [31:0] CTL_RUN    = 32'b1100000;
    localparam logic [31:0] CTL_STALL  = 32'b0010000;
    localparam logic [31:0] CTL_FLUSH  = 32'b1101110;
    localparam logic [31:0] CTL_FREEZE = 32'b0000001;

    task automatic drive(input logic mr, input logic [4:0] wr, input logic [4:0] rn,
                         input logic [4:0] rm, input logic urm, input logic br,
                         input logic busy);
        idex_memread   = mr;
        idex_write_reg = wr;
        ifid_rn        = rn;
        ifid_rm        = rm;
        ifid_uses_rm   = urm;
        branch_taken   = br;
        dmem_busy      = busy;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        check_eq("reset_ctl", ctl(), CTL_RESET);
        step();
        check_eq("reset_state", {30'd0, state}, 32'd0);
        check_eq("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check_eq("reset_flush_cnt", {16'd0, flush_cnt}, 32'd0);
        check_eq("reset_freeze_cnt", {16'd0, freeze_cnt}, 32'd0);
        check_eq("reset_err", {31'd0, err}, 32'd0);
        reset = 1'b0;

        // Load X1 then ADD X2,X1,X3: one stall, then run.
        drive(1'b1, 5'd1, 5'd1, 5'd3, 1'b1, 1'b0, 1'b0);
        check_eq("lu_rn_ctl", ctl(), CTL_STALL);
        step();
        idle();
        check_eq("after_stall_ctl", ctl(), CTL_RUN);
        check_eq("after_stall_state", {30'd0, state}, 32'd1);
        check_eq("after_stall_cnt", {16'd0, stall_cnt}, 32'd1);
        step();
        check_eq("back_to_run_state", {30'd0, state}, 32'd0);

        // Hazard through rm only counts when the instruction reads rm.
        drive(1'b1, 5'd7, 5'd2, 5'd7, 1'b1, 1'b0, 1'b0);
        check_eq("lu_rm_ctl", ctl(), CTL_STALL);
        drive(1'b1, 5'd7, 5'd2, 5'd7, 1'b0, 1'b0, 1'b0);
        check_eq("rm_unused_ctl", ctl(), CTL_RUN);
        drive(1'b0, 5'd7, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0);
        check_eq("no_memread_ctl", ctl(), CTL_RUN);

        // XZR destination never stalls.
        do_reset();
        drive(1'b1, 5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 1'b0);
        check_eq("xzr_ctl", ctl(), CTL_RUN);
        step();
        idle();
        check_eq("xzr_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        check_eq("xzr_state", {30'd0, state}, 32'd0);

        // Branch beats load-use.
        do_reset();
        drive(1'b1, 5'd1, 5'd1, 5'd0, 1'b0, 1'b1, 1'b0);
        check_eq("br_lu_ctl", ctl(), CTL_FLUSH);
        step();
        idle();
        check_eq("br_lu_state", {30'd0, state}, 32'd2);
        check_eq("br_lu_flush_cnt", {16'd0, flush_cnt}, 32'd1);
        check_eq("br_lu_stall_cnt", {16'd0, stall_cnt}, 32'd0);

        // Freeze for 5 cycles with a pending branch, then exactly one flush.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'd1, 5'd1, 5'd0, 1'b0, 1'b1, 1'b1);
            check_eq($sformatf("freeze_ctl_%0d", i), ctl(), CTL_FREEZE);
            step();
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        check_eq("post_freeze_ctl", ctl(), CTL_FLUSH);
        check_eq("post_freeze_state", {30'd0, state}, 32'd3);
        check_eq("post_freeze_freeze_cnt", {16'd0, freeze_cnt}, 32'd5);
        step();
        idle();
        check_eq("after_flush_ctl", ctl(), CTL_RUN);
        check_eq("after_flush_state", {30'd0, state}, 32'd2);
        check_eq("after_flush_flush_cnt", {16'd0, flush_cnt}, 32'd1);
        check_eq("after_flush_freeze_cnt", {16'd0, freeze_cnt}, 32'd5);
        check_eq("after_flush_err", {31'd0, err}, 32'd0);

        // Freeze timeout: err sets on the 64th consecutive freeze edge.
        do_reset();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 63; i++) step();
        check_eq("timeout_63_err", {31'd0, err}, 32'd0);
        step();
        check_eq("timeout_64_err", {31'd0, err}, 32'd1);
        check_eq("timeout_freeze_cnt", {16'd0, freeze_cnt}, 32'd64);
        idle();
        step();
        check_eq("timeout_sticky_err", {31'd0, err}, 32'd1);

        // Reset mid-freeze applies the reset row and returns to RUN.
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        step();
        reset = 1'b1;
        #1;
        check_eq("reset_mid_freeze_ctl", ctl(), CTL_RESET);
        step();
        check_eq("reset_mid_freeze_state", {30'd0, state}, 32'd0);
        check_eq("reset_clears_err", {31'd0, err}, 32'd0);
        reset = 1'b0;
        idle();

        // Two consecutive load-use cycles are a protocol error; then saturate stall_cnt.
        drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0, 1'b0);
        step();
        check_eq("dbl_stall_first_err", {31'd0, err}, 32'd0);
        step();
        check_eq("dbl_stall_err", {31'd0, err}, 32'd1);
        for (int i = 2; i < 65535; i++) step();
        check_eq("stall_cnt_full", {16'd0, stall_cnt}, 32'h0000_FFFF);
        step();
        check_eq("stall_cnt_saturate", {16'd0, stall_cnt}, 32'h0000_FFFF);
        check_eq("sat_flush_cnt", {16'd0, flush_cnt}, 32'd0);
        check_eq("sat_state", {30'd0, state}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
